// File: rtl/dm_if.sv
// dm_if: load/store request/response channel between the core (master) and
// a data-memory responder (slave).
//   req_valid/req_ready  request handshake; req_we, req_addr, req_wdata, req_be
//   resp_valid/resp_ready response handshake; resp_rdata, resp_err
`timescale 1ns/1ps
interface dm_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: data-memory target that accepts one load/store at a time and
// answers after WAIT_CYCLES+1 clock edges. Stores honour byte enables; illegal
// lane/alignment pairs or out-of-range addresses give an error response with
// no memory side effect.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset (clears state and all memory words)
//   bus    dm_if.slave request/response channel
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request (req_ready=1)
// BUSY  | request latched, counting down wait states, access at cnt==0
// RESP  | response presented, held until resp_ready
`timescale 1ns/1ps
module dm_responder #(
    parameter int          ADDR_WIDTH  = 10,   // up to 29 (word index fits in 32-bit address)
    parameter int          WAIT_CYCLES = 2,    // 0..255
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000  // assumed word aligned
) (
    input  logic clk,
    input  logic reset,
    dm_if.slave  bus
);

    localparam int          DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [7:0]  WAIT_C = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]            r_cnt;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic [31:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_pair_ok;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_finish;

    // ---------------------------------------------------------------
    // Address decode and legality of the latched request
    // ---------------------------------------------------------------
    assign w_off      = r_addr - BASE_ADDR;
    assign w_idx      = w_off[ADDR_WIDTH+1:2];
    // Below-base addresses wrap w_off to a huge value, so the explicit
    // compare is needed in addition to the upper-bits check.
    assign w_in_range = (r_addr >= BASE_ADDR) && ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);

    always_comb begin
        w_pair_ok = 1'b0;
        case ({r_be, w_off[1:0]})
            6'b1111_00, 6'b0011_00, 6'b1100_10,
            6'b0001_00, 6'b0010_01, 6'b0100_10,
            6'b1000_11: w_pair_ok = 1'b1;
            default:    w_pair_ok = 1'b0;
        endcase
    end

    assign w_legal  = w_in_range && w_pair_ok;
    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_finish = (r_state == BUSY) && (r_cnt == 8'd0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid)  w_next = BUSY;
            BUSY:    if (r_cnt == 8'd0)  w_next = RESP;
            RESP:    if (bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (all response fields forced to 0 outside RESP)
    // ---------------------------------------------------------------
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.resp_err   = 1'b0;
        case (r_state)
            IDLE: bus.req_ready = reset;
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = r_rdata;
                bus.resp_err   = r_err;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= WAIT_C;
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
        end else if (r_state == BUSY) begin
            if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_err   <= !w_legal;
                r_rdata <= (w_legal && !r_we) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Memory array; written only at the completing edge of a legal store
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else if (w_finish && w_legal && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
module tb_dm_responder;

    localparam int WAITC = 2;
    localparam int WORDS = 1024;

    logic clk;
    logic rst_n;
    logic rst0_n;

    dm_if bus ();
    dm_if bus0 ();

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAITC), .BASE_ADDR(32'h0)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk   (clk),
        .reset (rst0_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    logic [31:0] mmem [WORDS];

    function automatic bit model_legal(input logic [3:0] be, input logic [31:0] a);
        logic [3:0] bes  [7];
        int         offs [7];
        bes[0] = 4'b1111; offs[0] = 0;
        bes[1] = 4'b0011; offs[1] = 0;
        bes[2] = 4'b1100; offs[2] = 2;
        bes[3] = 4'b0001; offs[3] = 0;
        bes[4] = 4'b0010; offs[4] = 1;
        bes[5] = 4'b0100; offs[5] = 2;
        bes[6] = 4'b1000; offs[6] = 3;
        for (int k = 0; k < 7; k++)
            if (be == bes[k] && (a % 4) == offs[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) mmem[i] = 32'd0;
    endtask

    task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] be, output logic [31:0] rd, output logic err);
        longint unsigned word;
        word = a / 4;
        err  = !((word < WORDS) && model_legal(be, a));
        rd   = 32'd0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mmem[word][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = mmem[word];
            end
        end
    endtask

    // ---------------- transaction driver (no checking) ----------------
    // lat = number of edges after the accept edge until resp_valid; -1 on timeout.
    task automatic run_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output logic err,
                           output int lat);
        lat = -1;
        rd  = 32'hxxxx_xxxx;
        err = 1'bx;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_be    = be;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) begin
                lat = n;
                break;
            end
        end
        if (lat > 0) begin
            rd  = bus.resp_rdata;
            err = bus.resp_err;
            @(negedge clk);
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1 bus.resp_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready);
        else n_pass++;
        n_total++;
        if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid);
        else n_pass++;
        n_total++;
        if (bus.resp_rdata !== 32'd0) $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata);
        else n_pass++;
        n_total++;
        if (bus.resp_err !== 1'b0) $display("FAIL reset_resp_err got=%b exp=0", bus.resp_err);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_word_byte();
        logic [31:0] rd, erd;
        logic        err, eerr;
        int          lat;
        model_access(1'b1, 32'h4, 32'hDEADBEEF, 4'b1111, erd, eerr);
        run_req(1'b1, 32'h4, 32'hDEADBEEF, 4'b1111, rd, err, lat);
        n_total++;
        if (lat !== WAITC + 1) $display("FAIL sw_latency got=%0d exp=%0d", lat, WAITC + 1);
        else n_pass++;
        n_total++;
        if (err !== 1'b0 || rd !== 32'd0) $display("FAIL sw_resp got=%b/%h exp=0/0", err, rd);
        else n_pass++;
        model_access(1'b0, 32'h4, 32'h0, 4'b1111, erd, eerr);
        run_req(1'b0, 32'h4, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("FAIL lw_word got=%h/%b exp=deadbeef/0", rd, err);
        else n_pass++;
        model_access(1'b1, 32'h5, 32'h0000AA00, 4'b0010, erd, eerr);
        run_req(1'b1, 32'h5, 32'h0000AA00, 4'b0010, rd, err, lat);
        n_total++;
        if (err !== 1'b0) $display("FAIL sb_err got=%b exp=0", err);
        else n_pass++;
        model_access(1'b0, 32'h4, 32'h0, 4'b1111, erd, eerr);
        run_req(1'b0, 32'h4, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (rd !== 32'hDEADAAEF) $display("FAIL lw_after_sb got=%h exp=deadaaef", rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic        err, eerr;
        int          lat;
        model_access(1'b1, 32'h6, 32'h11223344, 4'b1111, erd, eerr);
        run_req(1'b1, 32'h6, 32'h11223344, 4'b1111, rd, err, lat);
        n_total++;
        if (err !== 1'b1 || rd !== 32'd0) $display("FAIL misaligned_sw got=%b/%h exp=1/0", err, rd);
        else n_pass++;
        run_req(1'b0, 32'h4, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (rd !== 32'hDEADAAEF || err !== 1'b0) $display("FAIL lw_after_err got=%h/%b exp=deadaaef/0", rd, err);
        else n_pass++;
        run_req(1'b0, 32'h1000, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (err !== 1'b1 || rd !== 32'd0) $display("FAIL out_of_range got=%b/%h exp=1/0", err, rd);
        else n_pass++;
        run_req(1'b0, 32'h8, 32'h0, 4'b0000, rd, err, lat);
        n_total++;
        if (err !== 1'b1) $display("FAIL be_zero got=%b exp=1", err);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] erd;
        logic        eerr;
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          seen;
        model_access(1'b0, 32'h4, 32'h0, 4'b1111, erd, eerr);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h4;
        bus.req_be    = 4'b1111;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk);
            #1 seen = bus.resp_valid;
        end
        n_total++;
        if (!seen) $display("FAIL bp_timeout got=no_response exp=response");
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 32'h4;
            bus.req_wdata = 32'hFFFF_FFFF;
            bus.req_be    = 4'b1111;
            n_total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== erd || bus.req_ready !== 1'b0)
                $display("FAIL bp_hold c=%0d got=%b/%h/%b exp=1/%h/0", c,
                         bus.resp_valid, bus.resp_rdata, bus.req_ready, erd);
            else n_pass++;
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL bp_extra_accepted got=resp exp=none");
        else n_pass++;
        run_req(1'b0, 32'h4, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (rd !== erd) $display("FAIL bp_mem_unchanged got=%h exp=%h", rd, erd);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h8;
        bus.req_wdata = 32'h12345678;
        bus.req_be    = 4'b1111;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL abort_resp got=resp exp=none");
        else n_pass++;
        run_req(1'b0, 32'h8, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (rd !== 32'd0 || err !== 1'b0) $display("FAIL abort_lw8 got=%h/%b exp=0/0", rd, err);
        else n_pass++;
        run_req(1'b0, 32'h4, 32'h0, 4'b1111, rd, err, lat);
        n_total++;
        if (rd !== 32'd0) $display("FAIL reset_clears_mem got=%h exp=0", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  legal_be [7];
        logic [31:0] a, wd, rd, erd;
        logic [3:0]  be;
        logic        we, err, eerr;
        int          lat, k;
        legal_be[0] = 4'b1111; legal_be[1] = 4'b0011; legal_be[2] = 4'b1100;
        legal_be[3] = 4'b0001; legal_be[4] = 4'b0010; legal_be[5] = 4'b0100;
        legal_be[6] = 4'b1000;
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1));
            k  = int'($urandom_range(0, 9));
            if (k == 0)      a = 32'h1000 + $urandom_range(0, 32'hFFFF);
            else if (k == 1) a = $urandom_range(0, 4095);
            else             a = $urandom_range(0, 63);
            if ($urandom_range(0, 4) == 0) be = 4'($urandom_range(0, 15));
            else                           be = legal_be[$urandom_range(0, 6)];
            wd = $urandom;
            model_access(we, a, wd, be, erd, eerr);
            run_req(we, a, wd, be, rd, err, lat);
            n_total++;
            if (lat !== WAITC + 1) $display("FAIL rand_lat t=%0d got=%0d exp=%0d", t, lat, WAITC + 1);
            else n_pass++;
            n_total++;
            if (err !== eerr) $display("FAIL rand_err t=%0d a=%h be=%b got=%b exp=%b", t, a, be, err, eerr);
            else n_pass++;
            n_total++;
            if (rd !== erd) $display("FAIL rand_rdata t=%0d a=%h we=%b got=%h exp=%h", t, a, we, rd, erd);
            else n_pass++;
        end
    endtask

    task automatic test_wait0();
        int lat;
        @(negedge clk);
        rst0_n = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 32'h10;
        bus0.req_be    = 4'b1111;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus0.resp_valid) begin
                lat = n;
                break;
            end
        end
        n_total++;
        if (lat !== 1) $display("FAIL wait0_latency got=%0d exp=1", lat);
        else n_pass++;
        n_total++;
        if (bus0.resp_rdata !== 32'd0 || bus0.resp_err !== 1'b0)
            $display("FAIL wait0_resp got=%h/%b exp=0/0", bus0.resp_rdata, bus0.resp_err);
        else n_pass++;
        @(negedge clk);
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
        n_total++;
        if (bus0.resp_valid !== 1'b0) $display("FAIL wait0_release got=%b exp=0", bus0.resp_valid);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        rst0_n = 1'b0;
        bus.req_valid  = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
        bus.req_wdata  = 32'd0; bus.req_be = 4'd0; bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0;
        bus0.req_wdata = 32'd0; bus0.req_be = 4'd0; bus0.resp_ready = 1'b0;
        test_reset();
        test_word_byte();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wait0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
